// File: rtl/tdc_evfifo_pkg.sv
// rtl/tdc_evfifo_pkg.sv - register map, field positions and shared helpers for the TDC event FIFO
package tdc_evfifo_pkg;

    localparam logic [9:0] REG_STATUS = 10'd0;
    localparam logic [9:0] REG_DATA   = 10'd1;
    localparam logic [9:0] REG_DROPS  = 10'd2;
    localparam logic [9:0] REG_CTRL   = 10'd3;

    localparam int STAT_EMPTY_BIT = 16;
    localparam int STAT_FULL_BIT  = 17;
    localparam int STAT_OVF_BIT   = 18;

    localparam int CTRL_EN0_BIT   = 0;
    localparam int CTRL_EN1_BIT   = 1;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int CTRL_THR_LSB   = 16;

    localparam logic [15:0] THR_RESET = 16'd1;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/tdc_evfifo_mem.sv
// rtl/tdc_evfifo_mem.sv - single-clock show-ahead FIFO with block-RAM storage
module tdc_evfifo_mem #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [AW:0]   level_q, level_d;
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full_o     = level_q[AW];
        empty_o    = (level_q == '0);
        push_ok    = push_i & ~level_q[AW];
        pop_ok     = pop_i & (level_q != '0);
        rd_next    = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_ptr_d   = rd_next;
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d    = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
        // The RAM read port misses a same-cycle write to the next head slot; forward it instead.
        byp_d      = push_ok && (wr_ptr_q == rd_next);
        byp_data_d = push_data_i;
        head_o     = byp_q ? byp_data_q : ram_q;
        level_o    = level_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data_i;
        end
        ram_q <= mem[rd_next];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: rtl/tdc_evfifo.sv
// rtl/tdc_evfifo.sv - two-channel TDC event capture, arbitration into a FIFO, CSR access and level IRQ
module tdc_evfifo
    import tdc_evfifo_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h2,
    parameter int         depth_log2 = 9,
    parameter int         ts_width   = 31
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [13:0]         csr_a,
    input  logic                csr_we,
    input  logic [31:0]         csr_di,
    output logic [31:0]         csr_do,
    input  logic [1:0]          ev_stb_i,
    input  logic [ts_width-1:0] ev_ts0_i,
    input  logic [ts_width-1:0] ev_ts1_i,
    output logic                irq
);

    localparam int EW = ts_width + 1;
    localparam int LW = depth_log2 + 1;

    logic                hold0_v_q, hold0_v_d, hold1_v_q, hold1_v_d;
    logic [ts_width-1:0] hold0_ts_q, hold0_ts_d, hold1_ts_q, hold1_ts_d;
    ch_e                 rr_q, rr_d;
    logic [15:0]         drops_q, drops_d;
    logic                ovf_q, ovf_d;
    logic [1:0]          en_q, en_d;
    logic                irq_en_q, irq_en_d;
    logic [15:0]         thr_q, thr_d;
    logic                irq_q, irq_d;
    logic [31:0]         csr_do_q, csr_do_d;

    logic          csr_sel, wr_status, wr_data, wr_drops, wr_ctrl;
    logic          grant0, grant1, push, pop;
    logic          stb0, stb1, accept0, accept1, drop0, drop1;
    logic [EW-1:0] push_data, fifo_head;
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;
    logic [15:0]   thr_eff;
    logic [31:0]   rdata;
    logic          unused_di;

    assign unused_di = ^csr_di[15:3];

    tdc_evfifo_mem #(
        .DW(EW),
        .AW(depth_log2)
    ) u_mem (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        csr_sel   = (csr_a[13:10] == csr_addr);
        wr_status = csr_sel & csr_we & (csr_a[9:0] == REG_STATUS);
        wr_data   = csr_sel & csr_we & (csr_a[9:0] == REG_DATA);
        wr_drops  = csr_sel & csr_we & (csr_a[9:0] == REG_DROPS);
        wr_ctrl   = csr_sel & csr_we & (csr_a[9:0] == REG_CTRL);

        // Space is judged on the pre-pop level, so a same-cycle pop never makes room.
        grant0    = ~fifo_full & hold0_v_q & (~hold1_v_q | (rr_q == CH0));
        grant1    = ~fifo_full & hold1_v_q & (~hold0_v_q | (rr_q == CH1));
        push      = grant0 | grant1;
        push_data = grant0 ? {1'b0, hold0_ts_q} : {1'b1, hold1_ts_q};
        pop       = wr_data;
        rr_d      = push ? ((rr_q == CH0) ? CH1 : CH0) : rr_q;

        stb0      = ev_stb_i[0] & en_q[0];
        stb1      = ev_stb_i[1] & en_q[1];
        accept0   = stb0 & (~hold0_v_q | grant0);
        accept1   = stb1 & (~hold1_v_q | grant1);
        drop0     = stb0 & ~accept0;
        drop1     = stb1 & ~accept1;

        hold0_v_d  = accept0 | (hold0_v_q & ~grant0);
        hold1_v_d  = accept1 | (hold1_v_q & ~grant1);
        hold0_ts_d = accept0 ? ev_ts0_i : hold0_ts_q;
        hold1_ts_d = accept1 ? ev_ts1_i : hold1_ts_q;

        drops_d = sat_add16(wr_drops ? 16'd0 : drops_q, {1'b0, drop0} + {1'b0, drop1});
        ovf_d   = drop0 | drop1 | (ovf_q & ~(wr_status & csr_di[STAT_OVF_BIT]));

        en_d     = en_q;
        irq_en_d = irq_en_q;
        thr_d    = thr_q;
        if (wr_ctrl) begin
            en_d     = {csr_di[CTRL_EN1_BIT], csr_di[CTRL_EN0_BIT]};
            irq_en_d = csr_di[CTRL_IRQEN_BIT];
            thr_d    = csr_di[CTRL_THR_LSB +: 16];
        end

        thr_eff = (thr_q == 16'd0) ? 16'd1 : thr_q;
        irq_d   = irq_en_q & (32'(fifo_level) >= 32'(thr_eff));

        rdata = '0;
        case (csr_a[9:0])
            REG_STATUS: begin
                rdata[15:0]           = 16'(fifo_level);
                rdata[STAT_EMPTY_BIT] = fifo_empty;
                rdata[STAT_FULL_BIT]  = fifo_full;
                rdata[STAT_OVF_BIT]   = ovf_q;
            end
            REG_DATA:  rdata = fifo_empty ? 32'd0 : 32'(fifo_head);
            REG_DROPS: rdata = {16'd0, drops_q};
            REG_CTRL:  rdata = {thr_q, 13'd0, irq_en_q, en_q};
            default:   rdata = '0;
        endcase
        csr_do_d = csr_sel ? rdata : 32'd0;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hold0_v_q  <= 1'b0;
            hold1_v_q  <= 1'b0;
            hold0_ts_q <= '0;
            hold1_ts_q <= '0;
            rr_q       <= CH0;
            drops_q    <= '0;
            ovf_q      <= 1'b0;
            en_q       <= 2'b00;
            irq_en_q   <= 1'b0;
            thr_q      <= THR_RESET;
            irq_q      <= 1'b0;
            csr_do_q   <= '0;
        end else begin
            hold0_v_q  <= hold0_v_d;
            hold1_v_q  <= hold1_v_d;
            hold0_ts_q <= hold0_ts_d;
            hold1_ts_q <= hold1_ts_d;
            rr_q       <= rr_d;
            drops_q    <= drops_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            thr_q      <= thr_d;
            irq_q      <= irq_d;
            csr_do_q   <= csr_do_d;
        end
    end

    assign csr_do = csr_do_q;
    assign irq    = irq_q;

endmodule
